// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int   FRAME_BITS  = 11;
  localparam int   DATA_BITS   = FRAME_BITS - 3;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/ps2_rx_if.sv
// Byte output channel of the PS/2 receiver: valid/ready handshake plus sticky error.
interface ps2_rx_if;

  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_error;

  modport master (output rx_valid, output rx_data, output rx_error, input rx_ready);
  modport slave  (input rx_valid, input rx_data, input rx_error, output rx_ready);

endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a run-length filter; idles high like an open-collector line.
module ps2_line_filter #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic reset_low,
  input  logic pin,
  output logic level
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] run_cnt;

  always_ff @(posedge clk) begin
    if (!reset_low) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync_1  <= 1'b1;
      sync_2  <= 1'b1;
      level   <= 1'b1;
      run_cnt <= '0;
    end else begin
      sync_1 <= pin;
      sync_2 <= sync_1;
      // Any sample matching the current level restarts the run, so short pulses are absorbed.
      if (sync_2 == level) begin
        run_cnt <= '0;
      end else if (run_cnt == CNT_W'(FILTER_CYCLES - 1)) begin
        level   <= sync_2;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver with timeout, sticky error and a one-entry output stage.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 148_500
) (
  input  logic      clk,
  input  logic      reset_low,
  input  logic      ps2_clk_pin,
  input  logic      ps2_data_pin,
  ps2_rx_if.master  rx
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             clk_level;
  logic             data_level;
  logic             clk_level_q;
  logic             fall;
  state_t           state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             parity_ok;
  logic [TMO_W-1:0] tmo_cnt;

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
    .clk       (clk),
    .reset_low (reset_low),
    .pin       (ps2_clk_pin),
    .level     (clk_level)
  );

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
    .clk       (clk),
    .reset_low (reset_low),
    .pin       (ps2_data_pin),
    .level     (data_level)
  );

  assign fall = clk_level_q & ~clk_level;

  always_ff @(posedge clk) begin
    if (!reset_low) begin
      clk_level_q <= 1'b1;
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      parity_ok   <= 1'b0;
      tmo_cnt     <= '0;
      rx.rx_valid <= 1'b0;
      rx.rx_data  <= '0;
      rx.rx_error <= 1'b0;
    end else begin
      clk_level_q <= clk_level;

      // NOTE: a later assignment to rx_valid in this block overrides this clear (load during transfer).
      if (rx.rx_valid && rx.rx_ready) rx.rx_valid <= 1'b0;

      if (state == IDLE || fall) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES)) begin
        tmo_cnt     <= '0;
        state       <= IDLE;
        rx.rx_error <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (fall) begin
        unique case (state)
          IDLE: begin
            if (data_level == START_LEVEL) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              rx.rx_error <= 1'b1;
            end
          end
          DATA: begin
            shift   <= {data_level, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'(DATA_BITS - 1)) state <= PARITY;
          end
          PARITY: begin
            parity_ok <= (^shift) ^ data_level;
            state     <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (data_level == STOP_LEVEL && parity_ok) begin
              if (!rx.rx_valid || rx.rx_ready) begin
                rx.rx_valid <= 1'b1;
                rx.rx_data  <= shift;
              end else begin
                rx.rx_error <= 1'b1;
              end
            end else begin
              rx.rx_error <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed scenarios plus randomized frames against a frame-level model.
module tb_ps2_rx;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 20;

  logic clk = 1'b0;
  logic reset_low = 1'b0;
  logic ps2_clk_pin = 1'b1;
  logic ps2_data_pin = 1'b1;

  ps2_rx_if bus ();

  ps2_rx #(.FILTER_CYCLES(FILTER), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk          (clk),
    .reset_low    (reset_low),
    .ps2_clk_pin  (ps2_clk_pin),
    .ps2_data_pin (ps2_data_pin),
    .rx           (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         valid_cycles = 0;
  logic       exp_err = 1'b0;

  always @(negedge clk) begin
    if (bus.rx_valid) valid_cycles++;
    if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycles(1);
    reset_low = 1'b0;
    cycles(2);
    reset_low = 1'b1;
    exp_err = 1'b0;
    got_q.delete();
    exp_q.delete();
    valid_cycles = 0;
  endtask

  task automatic send_bit(input logic b);
    ps2_data_pin = b;
    cycles(HALF);
    ps2_clk_pin = 1'b0;
    cycles(HALF);
    ps2_clk_pin = 1'b1;
  endtask

  // Drives one frame; the model decides from the frame rules whether it is good.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(~bad_stop);
    ps2_data_pin = 1'b1;
    cycles(2 * HALF);
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, got_q[i], exp_q[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, bus.rx_valid, 1'b0);
    check({tag, "_data"},  bus.rx_data,  8'h00);
    check({tag, "_error"}, bus.rx_error, 1'b0);
    cycles(1);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_ready = 1'b1;
    cycles(3);
    reset_low = 1'b1;
    check_reset_outputs("reset");

    // 1: good frame, consumer ready
    valid_cycles = 0;
    send_frame(8'h1C, 1'b0, 1'b0);
    exp_q.push_back(8'h1C);
    compare_rx("good");
    check("good_valid_cycles", valid_cycles, 1);
    check("good_error", bus.rx_error, 1'b0);

    // 2: parity error then a good frame
    send_frame(8'h1C, 1'b1, 1'b0);
    check("par_error", bus.rx_error, 1'b1);
    compare_rx("par_drop");
    send_frame(8'hF0, 1'b0, 1'b0);
    exp_q.push_back(8'hF0);
    compare_rx("par_next");
    check("par_sticky", bus.rx_error, 1'b1);

    // 3: overrun with consumer stalled
    do_reset();
    check_reset_outputs("reset2");
    bus.rx_ready = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b0);
    check("ovr_first_err", bus.rx_error, 1'b0);
    send_frame(8'h32, 1'b0, 1'b0);
    @(negedge clk);
    check("ovr_valid", bus.rx_valid, 1'b1);
    check("ovr_data", bus.rx_data, 8'h1C);
    check("ovr_error", bus.rx_error, 1'b1);
    cycles(1);
    bus.rx_ready = 1'b1;
    cycles(5);
    exp_q.push_back(8'h1C);
    compare_rx("ovr");
    check("ovr_drained", bus.rx_valid, 1'b0);

    // 4: timeout after four data bits
    do_reset();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    ps2_data_pin = 1'b1;
    check("tmo_before", bus.rx_error, 1'b0);
    cycles(TIMEOUT + 100);
    check("tmo_error", bus.rx_error, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b0);
    exp_q.push_back(8'h5A);
    compare_rx("tmo_next");

    // 5: short clock glitch in idle
    do_reset();
    ps2_clk_pin = 1'b0;
    cycles(3);
    ps2_clk_pin = 1'b1;
    cycles(4 * FILTER);
    check("glitch_error", bus.rx_error, 1'b0);
    check("glitch_valid", bus.rx_valid, 1'b0);
    send_frame(8'h66, 1'b0, 1'b0);
    exp_q.push_back(8'h66);
    compare_rx("glitch_next");

    // 6: reset pulse in the middle of the data bits
    do_reset();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    reset_low = 1'b0;
    cycles(1);
    reset_low = 1'b1;
    got_q.delete();
    @(negedge clk);
    check("mid_rst_valid", bus.rx_valid, 1'b0);
    check("mid_rst_data",  bus.rx_data,  8'h00);
    check("mid_rst_error", bus.rx_error, 1'b0);
    ps2_data_pin = 1'b1;
    cycles(4 * HALF);
    send_frame(8'h29, 1'b0, 1'b0);
    exp_q.delete();
    exp_q.push_back(8'h29);
    compare_rx("mid_rst_next");
    check("mid_rst_next_err", bus.rx_error, 1'b0);

    // Randomized frames: mostly good, some with bad parity or bad stop bit
    do_reset();
    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      int kind;
      b = 8'($urandom);
      kind = $urandom_range(0, 9);
      send_frame(b, kind == 0, kind == 1);
      if (kind > 1) exp_q.push_back(b);
      else exp_err = 1'b1;
      check("rand_error", bus.rx_error, exp_err);
    end
    compare_rx("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

PS/2 keyboard receive front end. It samples the open-collector `ps2_clk_pin` and `ps2_data_pin` lines in the system clock domain and decodes 11-bit device-to-host frames. Each good data byte is delivered through a one-entry valid/ready output stage. It sits between the keyboard pins and the character-writing logic, for example the vram write port. Bytes are raw scan codes; no translation is done.

## Interface
Parameters:
- `FILTER_CYCLES`, default 8: consecutive equal synchronized samples required before a line level is accepted.
- `TIMEOUT_CYCLES`, default 148_500 (about 2 ms at 74.25 MHz): idle cycles allowed between PS/2 clock falling edges inside a frame.

Ports:
- `clk` input 1: system clock; every flop uses the rising edge.
- `reset_low` input 1: reset is synchronous and active-low.
- `ps2_clk_pin` input 1: raw PS/2 clock, asynchronous.
- `ps2_data_pin` input 1: raw PS/2 data, asynchronous.
- `rx_ready` input 1: consumer accepts `rx_data` this cycle.
- `rx_valid` output 1: `rx_data` holds an unconsumed byte.
- `rx_data` output 8: received byte.
- `rx_error` output 1: sticky error flag.

## Operation
- **Input conditioning.** Each pin passes through a 2-flop synchronizer, then a filter. The filtered level changes only after `FILTER_CYCLES` consecutive identical samples. Reset sets both filtered levels to 1 (idle).
- **Edge detect.** A falling-edge pulse is one cycle long, when the filtered clock goes from 1 to 0. Data is sampled from the filtered data level in that same cycle.
- **Frame format.** Start bit = 0, then 8 data bits LSB first, then odd parity, then stop bit = 1.
- **State machine.**
  - IDLE: on a falling edge with data = 0, go to DATA with the bit count cleared. On a falling edge with data = 1, set `rx_error` and stay in IDLE.
  - DATA: shift 8 bits in, LSB first. After the eighth bit, go to PARITY.
  - PARITY: check that the XOR of the 8 data bits and the parity bit is 1. Go to STOP.
  - STOP: on the edge, the frame is good if data = 1 and parity was OK. A good frame loads the output stage. Otherwise set `rx_error` and discard the frame. Return to IDLE either way.
- **Timeout.** In any state other than IDLE, a cycle counter counts up and is cleared on every falling edge. When it reaches `TIMEOUT_CYCLES`, abort to IDLE, discard the partial frame and set `rx_error`.
- **Output stage.**
  - A good frame sets `rx_valid` = 1 and `rx_data` = the byte.
  - A transfer happens when `rx_valid` and `rx_ready` are both 1; `rx_valid` then clears.
  - `rx_data` is held stable while `rx_valid` = 1.
  - Good frame completing while `rx_valid` = 1 with no transfer that cycle: overrun. The old byte is kept, the new byte is dropped and `rx_error` is set.
  - Good frame completing in the same cycle as a transfer: the new byte loads and `rx_valid` stays 1.
- **Error flag.** `rx_error` is sticky and is cleared only by reset.

## Timing
- **Reset.** While `reset_low` = 0 at a clock edge, all of the following are forced:
  - `rx_valid` = 0, `rx_data` = 0x00, `rx_error` = 0;
  - state = IDLE, bit and timeout counters = 0;
  - synchronizer and filter levels = 1.
- **Reset mid-frame.** The partial frame is discarded; reception resumes at the next start bit after reset is released.
- **Pin-to-edge latency.** The falling-edge pulse occurs 2 + `FILTER_CYCLES` cycles after a clean pin transition.
- **Edge-to-output latency.** The stop-bit edge pulse is at cycle N; `rx_valid` = 1 and the new `rx_data` appear at cycle N+1.
- **Transfer.** A transfer at cycle T gives `rx_valid` = 0 at T+1, unless a new byte loaded at T.
- **Error latency.** `rx_error` rises one cycle after the detecting edge, or one cycle after the timeout expires.
- **Rejected glitches.** A pin pulse shorter than `FILTER_CYCLES` cycles produces no edge and no state change.

## Structure
- Shared package `ps2_pkg` holds:
  - state enum: IDLE, DATA, PARITY, STOP;
  - constants: frame length 11, start level 0, stop level 1.
- Sub-module `ps2_line_filter` contains the 2-flop synchronizer and the filter, with a reset value of 1. It is instantiated once per pin.
- The edge detector, frame FSM, timeout counter and output stage live in `ps2_rx`.

## Test plan
1. **Good frame, consumer ready.** Send a frame for 0x1C (bits 0,00111000,0,1) with `rx_ready` = 1. Expect `rx_valid` high for exactly 1 cycle with `rx_data` = 0x1C, and `rx_error` = 0.
2. **Parity error.** Send 0x1C with parity = 1. Expect no `rx_valid` and `rx_error` = 1 until reset; a following good frame 0xF0 is still delivered.
3. **Overrun.** Hold `rx_ready` = 0 and send 0x1C then 0x32. Expect `rx_data` = 0x1C held with `rx_valid` = 1 and `rx_error` set. After raising `rx_ready`, exactly one transfer of 0x1C.
4. **Timeout.** Stop the clock after 4 bits for more than `TIMEOUT_CYCLES`. Expect `rx_error` = 1; a subsequent full frame 0x5A is received correctly.
5. **Glitch rejection.** Apply a 3-cycle low pulse on `ps2_clk_pin` in IDLE with `FILTER_CYCLES` = 8. Expect no state change and no error.
6. **Reset mid-frame.** Drop `reset_low` for 1 cycle during the data bits. Expect all outputs at reset values and the next full frame 0x29 received correctly.
